// File: rtl/cla_mp_add_seq.sv
// Multi-precision add/subtract sequencer: one W-bit carry-lookahead slice is reused
// across N slices, one slice per cycle, with the inter-slice carry held in a register.
module cla_mp_add_seq #(
    parameter int W = 8,
    parameter int N = 4
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic           op_i,
    input  logic [W*N-1:0] a_i,
    input  logic [W*N-1:0] b_i,
    input  logic           cin_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [W*N-1:0] s_o,
    output logic           cout_o,
    output logic           ovf_o,
    output logic           busy_o,
    output logic [1:0]     state_o
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; in_ready and out_valid are registered and never high in the same cycle.

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int DW = W * N;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   idx_q;
    logic            cr_q;
    logic [DW-1:0]   a_q;
    logic [DW-1:0]   b_q;
    logic [DW-1:0]   s_q;
    logic            cout_q;
    logic            ovf_q;
    logic            out_valid_q;
    logic            in_ready_q;
    logic            busy_q;

    logic [W-1:0]    a_sl;
    logic [W-1:0]    b_sl;
    logic [W-1:0]    gen;
    logic [W-1:0]    prp;
    logic [W:0]      carry;
    logic [W-1:0]    sum_d;
    logic            co_d;
    logic            last_slice;

    // Every carry is a flat sum of products of g/p and the slice carry-in.
    function automatic logic [W:0] cla_carry(input logic [W-1:0] g, input logic [W-1:0] p,
                                             input logic ci);
        logic [W:0] c;
        logic       term;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < W; i++) begin
            c[i+1] = g[i];
            term   = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (term & g[j]);
                term   = term & p[j];
            end
            c[i+1] = c[i+1] | (term & ci);
        end
        return c;
    endfunction

    always_comb begin
        a_sl       = a_q[int'(idx_q)*W +: W];
        b_sl       = b_q[int'(idx_q)*W +: W];
        gen        = a_sl & b_sl;
        prp        = a_sl ^ b_sl;
        carry      = cla_carry(gen, prp, cr_q);
        sum_d      = prp ^ carry[W-1:0];
        co_d       = carry[W];
        last_slice = (idx_q == IW'(N - 1));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cr_q        <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid_i && in_ready_q) begin
                        a_q        <= a_i;
                        b_q        <= op_i ? ~b_i : b_i;
                        cr_q       <= op_i ? 1'b1 : cin_i;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    s_q[int'(idx_q)*W +: W] <= sum_d;
                    cr_q                    <= co_d;
                    if (last_slice) begin
                        cout_q      <= co_d;
                        ovf_q       <= (a_sl[W-1] == b_sl[W-1]) && (sum_d[W-1] != a_sl[W-1]);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign s_o         = s_q;
    assign cout_o      = cout_q;
    assign ovf_o       = ovf_q;
    assign busy_o      = busy_q;
    assign state_o     = state_q;

endmodule

// File: doc/cla_mp_add_seq.md
# cla_mp_add_seq

Multi-precision add/subtract sequencer that time-shares one W-bit carry-lookahead slice across N slices of a W·N-bit operand pair. It processes one slice per cycle and holds the inter-slice carry in a register. It sits between a valid/ready operand source and a valid/ready result sink. It sequences the team's existing CLA datapath (generate/propagate, carry, and final XOR sum cells) and does not replace it.

## Interface
- W, default 8: width of the CLA slice in bits, ≥ 2.
- N, default 4: number of slices per operation, ≥ 1. Operand width is W·N.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept a request (registered).
- op  in  1  0 = a + b + cin, 1 = a − b (b inverted, carry-in forced 1, cin ignored).
- a  in  W·N  operand A, sampled only at the input handshake.
- b  in  W·N  operand B, sampled only at the input handshake.
- cin  in  1  carry-in for add.
- out_valid  out  1  result available.
- out_ready  in  1  sink accepts the result.
- s  out  W·N  sum or difference.
- cout  out  1  carry out of the MSB. For subtract, 1 = no borrow.
- ovf  out  1  two's-complement overflow of the W·N-bit result.
- busy  out  1  high in RUN and DONE.

## Operation
- FSM states: IDLE, RUN, DONE. Slice index idx is ceil(log2(N))-bit wide (1 bit when N = 1). Carry register cr is 1 bit.
- Reset (rst_n low, asynchronous):
  - State returns to IDLE.
  - idx, cr, operand registers, s, cout, ovf, out_valid, in_ready and busy are all cleared to 0.
- IDLE:
  - in_ready = 1 from the first rising edge after rst_n deasserts.
  - On in_valid & in_ready: latch a. Latch b (or ~b when op = 1). Load cr = op ? 1 : cin. Set idx = 0. Go to RUN. in_ready goes to 0.
- RUN, each cycle:
  - Slice result = A[idx] + B'[idx] + cr, computed by the W-bit CLA.
  - The W-bit slice result is written into s[idx·W +: W], and cr is updated with the slice carry-out.
  - If idx = N−1: cout is loaded with the carry-out. ovf = (A_msb == B'_msb) & (s_msb != A_msb), using the final slice bits. Go to DONE and set out_valid = 1.
  - Otherwise idx increments by 1. idx never wraps past N−1.
- DONE:
  - out_valid = 1. s, cout and ovf are held stable.
  - On out_ready: out_valid goes to 0, go to IDLE, and in_ready goes to 1 on the same edge.
  - in_valid is ignored while in DONE.
- s retains its previous value outside DONE. Slices not yet written during RUN hold stale data. Consumers sample s only while out_valid = 1.
- Result is exact modulo 2^(W·N). cout and ovf follow the standard add/sub definitions above.

## Timing
- Handshake edge E0 is the edge where in_valid & in_ready are both high.
- Edges E1..EN process slices 0..N−1.
- out_valid is high after EN, so latency from acceptance to out_valid is N cycles.
- With out_ready held high, the result handshake occurs at edge EN+1. in_ready is high after EN+1. The earliest next acceptance is edge EN+2.
- Minimum initiation interval is N+2 cycles.
- in_ready and out_valid are never high in the same cycle.
- Asynchronous reset at any point, including mid-RUN, aborts the operation with no output handshake. The block resumes normal operation on the first edge after rst_n goes high.
- The critical path is one W-bit CLA plus the cr mux. The carry does not ripple across slices combinationally.

## Test plan
- W=8, N=4, op=0, a=0xFFFFFFFF, b=0x00000001, cin=0.
  - Required: s=0x00000000, cout=1, ovf=0.
  - out_valid rises exactly 4 cycles after acceptance.
- op=1, a=0x00000005, b=0x00000007.
  - Required: s=0xFFFFFFFE, cout=0, ovf=0.
- op=0, a=0x7FFFFFFF, b=0x00000001, cin=0.
  - Required: s=0x80000000, cout=0, ovf=1.
- op=0, a=0x12345678, b=0x0F0F0F0F, cin=1, with out_ready held low for 5 cycles after out_valid rises.
  - Required: s=0x21436588 held stable and in_ready=0 throughout.
  - A new in_valid pulse in that window is not accepted.
- Drop rst_n two cycles into RUN.
  - Required: out_valid=0, s=0, cout=0, ovf=0, busy=0 immediately, and in_ready=0 while reset is held.
  - in_ready=1 one edge after release. The next operation, 1+1, yields s=0x00000002.
- N=1, W=8, op=1, a=0x80, b=0x01.
  - Required: s=0x7F, cout=1, ovf=1, and latency 1 cycle.
